// File: rtl/fpadd_job_sequencer_if.sv
// Bundles the operand feed, the adder Go/ResultReady handshake and the
// result port of the job sequencer. The master modport is the sequencer's
// view; the slave modport is the view of everything around it.
interface fpadd_job_sequencer_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
);
    logic                   InValid;
    logic                   InReady;
    logic [31:0]            InA;
    logic [31:0]            InB;
    logic [31:0]            AddendA;
    logic [31:0]            AddendB;
    logic                   Go;
    logic                   ResultReady;
    logic [31:0]            Result;
    logic                   Zero;
    logic                   Inf;
    logic                   Nan;
    logic                   OutValid;
    logic                   OutReady;
    logic [31:0]            OutResult;
    logic [3:0]             OutFlags;
    logic [TAG_W-1:0]       OutTag;
    logic                   Busy;
    logic [$clog2(DEPTH):0] Count;

    modport master (
        input  InValid, InA, InB, ResultReady, Result, Zero, Inf, Nan, OutReady,
        output InReady, AddendA, AddendB, Go, OutValid, OutResult, OutFlags,
               OutTag, Busy, Count
    );

    modport slave (
        output InValid, InA, InB, ResultReady, Result, Zero, Inf, Nan, OutReady,
        input  InReady, AddendA, AddendB, Go, OutValid, OutResult, OutFlags,
               OutTag, Busy, Count
    );
endinterface

// File: rtl/fpadd_job_sequencer.sv
// Requester-side driver for a Go/ResultReady floating-point adder: queues
// operand pairs, runs one add at a time, watchdogs each job and hands the
// result downstream with a sequence tag and status flags.
module fpadd_job_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int TAG_W   = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    fpadd_job_sequencer_if.master     bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} state_t;

    state_t           stateReg, stateNext;
    logic [63:0]      fifoMem [DEPTH];
    logic [PW:0]      wrPtrReg, rdPtrReg;
    logic [PW:0]      count;
    logic             inReady, push, pop, rise, timeoutHit;
    logic [31:0]      addendAReg, addendBReg, outResultReg;
    logic [3:0]       outFlagsReg;
    logic [TAG_W-1:0] outTagReg, tagCntReg;
    logic [TW-1:0]    timerReg;
    logic             rdyQReg;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count      = wrPtrReg - rdPtrReg;
    assign inReady    = Reset && (count < (PW+1)'(DEPTH));
    assign push       = bus.InValid && inReady;
    assign rise       = bus.ResultReady && !rdyQReg;
    assign timeoutHit = (timerReg == TW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge Clock) begin
        if (!Reset) stateReg <= IDLE;
        else        stateReg <= stateNext;
    end

    // Next-state logic; the FIFO is popped only on entry into ISSUE.
    always_comb begin
        stateNext = stateReg;
        pop       = 1'b0;
        case (stateReg)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE:   stateNext = WAIT;
            WAIT: begin
                // A rise in the expiry cycle still counts as a normal completion.
                if (rise)            stateNext = CAPTURE;
                else if (timeoutHit) stateNext = DONE;
            end
            CAPTURE: stateNext = DONE;
            DONE: begin
                if (bus.OutReady) begin
                    if (count != '0) begin
                        pop       = 1'b1;
                        stateNext = ISSUE;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // FIFO pointers.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
        end else begin
            if (push) wrPtrReg <= wrPtrReg + 1'b1;
            if (pop)  rdPtrReg <= rdPtrReg + 1'b1;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge Clock) begin
        if (push) fifoMem[wrPtrReg[PW-1:0]] <= {bus.InA, bus.InB};
    end

    // Job datapath: operand load, watchdog timer, result capture and tagging.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            addendAReg   <= '0;
            addendBReg   <= '0;
            outResultReg <= '0;
            outFlagsReg  <= '0;
            outTagReg    <= '0;
            tagCntReg    <= '0;
            timerReg     <= '0;
            rdyQReg      <= 1'b0;
        end else begin
            rdyQReg <= bus.ResultReady;
            if (pop) begin
                addendAReg <= fifoMem[rdPtrReg[PW-1:0]][63:32];
                addendBReg <= fifoMem[rdPtrReg[PW-1:0]][31:0];
            end
            case (stateReg)
                ISSUE: begin
                    timerReg  <= '0;
                    outTagReg <= tagCntReg;
                end
                WAIT: begin
                    timerReg <= timerReg + 1'b1;
                    if (!rise && timeoutHit) begin
                        outResultReg <= '0;
                        outFlagsReg  <= 4'b1000;
                    end
                end
                CAPTURE: begin
                    outResultReg <= bus.Result;
                    outFlagsReg  <= {1'b0, bus.Nan, bus.Inf, bus.Zero};
                end
                DONE: begin
                    if (bus.OutReady) tagCntReg <= tagCntReg + TAG_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.InReady   = inReady;
    assign bus.AddendA   = addendAReg;
    assign bus.AddendB   = addendBReg;
    assign bus.Go        = (stateReg == ISSUE);
    assign bus.OutValid  = (stateReg == DONE);
    assign bus.OutResult = outResultReg;
    assign bus.OutFlags  = outFlagsReg;
    assign bus.OutTag    = outTagReg;
    assign bus.Busy      = (stateReg != IDLE) || (count != '0);
    assign bus.Count     = count;
endmodule

// File: tb/tb_fpadd_job_sequencer.sv
// Bench for fpadd_job_sequencer: directed jobs, a behavioural adder and a
// per-cycle scoreboard of the job stream.
module tb_fpadd_job_sequencer;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int TAG_W   = 8;
    localparam int NJ      = 16;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    logic        InValid = 1'b0;
    logic [31:0] InA = '0, InB = '0;
    logic        OutReady = 1'b1;
    logic        ResultReady = 1'b0;
    logic [31:0] Result = '0;
    logic        Zero = 1'b0, Inf = 1'b0, Nan = 1'b0;
    int          pushIdx = 0;

    fpadd_job_sequencer_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus();

    assign bus.InValid     = InValid;
    assign bus.InA         = InA;
    assign bus.InB         = InB;
    assign bus.OutReady    = OutReady;
    assign bus.ResultReady = ResultReady;
    assign bus.Result      = Result;
    assign bus.Zero        = Zero;
    assign bus.Inf         = Inf;
    assign bus.Nan         = Nan;

    fpadd_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus(bus)
    );

    // Job table: operands, adder delay after Go (0 = never completes),
    // the adder's sum, and its {Nan,Inf,Zero} flags.
    logic [31:0] tA [NJ] = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'hBF800000,
                             32'h7F800000, 32'h7FC00000, 32'h3F800000, 32'h40000000,
                             32'h3F800000, 32'h40400000, 32'h3F800000, 32'h40000000,
                             32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000};
    logic [31:0] tB [NJ] = '{32'h40000000, 32'h40400000, 32'h40A00000, 32'h3F800000,
                             32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000,
                             32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                             32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000};
    int          tD [NJ] = '{6, 3, 1, 2, 4, 5, 0, 64, 65, 2, 2, 2, 20, 2, 2, 3};
    logic [31:0] tR [NJ] = '{32'h40400000, 32'h40A00000, 32'h41100000, 32'h00000000,
                             32'h7F800000, 32'h7FC00000, 32'h40000000, 32'h40800000,
                             32'h40400000, 32'h40800000, 32'h40000000, 32'h40400000,
                             32'h40000000, 32'h40800000, 32'h40C00000, 32'h40400000};
    logic [2:0]  tF [NJ] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b000, 3'b000,
                             3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          idx;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic bit completes(input int i);
        return (tD[i] >= 1) && (tD[i] <= TIMEOUT);
    endfunction

    // Cycles from the Go cycle to the first OutValid cycle.
    function automatic int latOf(input int i);
        return completes(i) ? tD[i] + 2 : TIMEOUT + 1;
    endfunction

    // Scoreboard state.
    int          cyc = 0, goCyc = 0, curIdx = 0, curTag = 0, tagSinceRst = 0;
    int          goCount = 0, delivered = 0, maxCount = 0;
    bit          jobActive = 0, goExp = 0, rstPrev = 0, expOV, accept;
    logic [31:0] curA = '0, curB = '0;
    logic [31:0] resArr [NJ];
    logic [31:0] flArr  [NJ];
    logic [31:0] tagArr [NJ];

    // Per-cycle compare of every DUT output against the job-stream model.
    always @(negedge Clock) begin
        cyc++;
        if (rstPrev) begin
            chk("rst_count", bus.Count, 0);
            chk("rst_outvalid", bus.OutValid, 0);
            chk("rst_go", bus.Go, 0);
            chk("rst_busy", bus.Busy, 0);
            chk("rst_addend_a", bus.AddendA, 0);
            chk("rst_addend_b", bus.AddendB, 0);
            chk("rst_out_result", bus.OutResult, 0);
            chk("rst_out_flags", bus.OutFlags, 0);
            chk("rst_out_tag", bus.OutTag, 0);
        end
        if (!Reset) begin
            chk("in_ready_in_reset", bus.InReady, 0);
            q.delete();
            jobActive   = 0;
            goExp       = 0;
            tagSinceRst = 0;
            rstPrev     = 1;
        end else begin
            rstPrev = 0;
            chk("go_timing", bus.Go, goExp);
            if (bus.Go) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL go_without_job actual=1 required=0");
                end else begin
                    ent_t e;
                    e = q.pop_front();
                    curIdx = e.idx;
                    curA   = e.a;
                    curB   = e.b;
                    chk("issue_addend_a", bus.AddendA, e.a);
                    chk("issue_addend_b", bus.AddendB, e.b);
                end
                curTag    = tagSinceRst;
                tagSinceRst++;
                goCyc     = cyc;
                jobActive = 1;
                goCount++;
            end
            if (int'(bus.Count) > maxCount) maxCount = int'(bus.Count);
            chk("count", bus.Count, q.size());
            chk("in_ready", bus.InReady, q.size() < DEPTH);
            chk("busy", bus.Busy, jobActive || (q.size() > 0));
            if (jobActive) begin
                chk("addend_a_stable", bus.AddendA, curA);
                chk("addend_b_stable", bus.AddendB, curB);
            end
            expOV = jobActive && ((cyc - goCyc) >= latOf(curIdx));
            chk("out_valid", bus.OutValid, expOV);
            if (expOV) begin
                chk("out_result", bus.OutResult, completes(curIdx) ? tR[curIdx] : 32'h0);
                chk("out_flags", bus.OutFlags, completes(curIdx) ? {1'b0, tF[curIdx]} : 4'b1000);
                chk("out_tag", bus.OutTag, curTag % (1 << TAG_W));
            end
            accept = expOV && OutReady;
            if (accept) begin
                resArr[curIdx] = bus.OutResult;
                flArr[curIdx]  = bus.OutFlags;
                tagArr[curIdx] = bus.OutTag;
                $display("job %0d tag=%0d result=%h flags=%b", curIdx, bus.OutTag,
                         bus.OutResult, bus.OutFlags);
                delivered++;
                jobActive = 0;
            end
            goExp = !jobActive && (q.size() > 0);
            if (InValid && bus.InReady) q.push_back('{InA, InB, pushIdx});
        end
    end

    // Behavioural adder: drops ResultReady on Go, raises it tD cycles later.
    int armedCd = 0, aIdx = 0;
    bit armed = 0;
    always @(posedge Clock) begin
        #2;
        if (!Reset) begin
            ResultReady = 1'b0;
            armed       = 0;
        end else begin
            if (armed) begin
                armedCd--;
                if (armedCd == 0) begin
                    ResultReady = 1'b1;
                    Result      = tR[aIdx];
                    {Nan, Inf, Zero} = tF[aIdx];
                    armed       = 0;
                end
            end
            if (bus.Go) begin
                ResultReady = 1'b0;
                armed       = 0;
                if (q.size() > 0) begin
                    aIdx = q[0].idx;
                    if (tD[aIdx] > 0) begin
                        armed   = 1;
                        armedCd = tD[aIdx];
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic pushJob(input int i);
        int   n = 0;
        logic acc = 1'b0;
        InValid = 1'b1;
        InA     = tA[i];
        InB     = tB[i];
        pushIdx = i;
        while (!acc && n < 500) begin
            @(negedge Clock);
            acc = bus.InReady;
            @(posedge Clock);
            #1;
            n++;
        end
        InValid = 1'b0;
        chk("push_accept", acc, 1);
    endtask

    task automatic waitDelivered(input int target, input int limit);
        int n = 0;
        while (delivered < target && n < limit) begin
            step();
            n++;
        end
        chk("wait_delivered", delivered, target);
    endtask

    int g, d;
    initial begin
        for (int i = 0; i < NJ; i++) begin
            resArr[i] = '1;
            flArr[i]  = '1;
            tagArr[i] = '1;
        end
        repeat (3) step();
        Reset = 1'b1;
        step();

        // Single job: 1.0 + 2.0
        pushJob(0);
        waitDelivered(1, 100);
        chk("single_result", resArr[0], 32'h40400000);
        chk("single_flags", flArr[0], 0);
        chk("single_tag", tagArr[0], 0);

        // Back-to-back five jobs, including zero/inf/nan flag results
        g = goCount;
        for (int i = 1; i <= 5; i++) pushJob(i);
        waitDelivered(6, 400);
        chk("b2b_go_pulses", goCount - g, 5);
        chk("b2b_max_count", maxCount, 4);
        chk("b2b_tag_first", tagArr[1], 1);
        chk("b2b_tag_last", tagArr[5], 5);
        chk("flags_zero", flArr[3], 4'b0001);
        chk("flags_inf", flArr[4], 4'b0010);
        chk("flags_nan", flArr[5], 4'b0100);

        // Timeout, rise coinciding with expiry, late rise after timeout
        for (int i = 6; i <= 9; i++) pushJob(i);
        waitDelivered(10, 600);
        chk("timeout_flags", flArr[6], 4'b1000);
        chk("timeout_result", resArr[6], 0);
        chk("edge_rise_wins_flags", flArr[7], 0);
        chk("edge_rise_wins_result", resArr[7], 32'h40800000);
        chk("late_rise_flags", flArr[8], 4'b1000);
        chk("after_timeout_result", resArr[9], 32'h40800000);

        // Backpressure: hold OutReady low for 10 cycles in DONE
        OutReady = 1'b0;
        pushJob(10);
        pushJob(11);
        d = 0;
        while (!bus.OutValid && d < 200) begin
            step();
            d++;
        end
        chk("bp_reached_done", bus.OutValid, 1);
        g = goCount;
        repeat (10) step();
        chk("bp_no_go", goCount, g);
        OutReady = 1'b1;
        waitDelivered(12, 100);
        chk("bp_result_b", resArr[11], 32'h40400000);

        // Reset mid-WAIT with two jobs queued
        g = goCount;
        pushJob(12);
        pushJob(13);
        pushJob(14);
        d = 0;
        while (goCount == g && d < 100) begin
            step();
            d++;
        end
        repeat (4) step();
        d = delivered;
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        repeat (3) step();
        chk("rst_no_result", delivered, d);
        pushJob(15);
        waitDelivered(d + 1, 100);
        chk("post_rst_tag", tagArr[15], 0);
        chk("post_rst_result", resArr[15], 32'h40400000);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
